// File: rtl/bs_refill_pkg.sv
// Shared constants and FSM encoding for the bitstream FIFO refill scheduler.
package bs_refill_pkg;

  localparam int WORD_BYTES = 8;
  localparam int LEN_BITS   = 8;

  // Fixed state encoding kept compatible with existing debug tooling.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CALC  = 3'd1;
  localparam state_t ST_REQ   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

endpackage

// File: rtl/refill_credit.sv
// Tracks words requested but not yet written into the FIFO, and the free
// FIFO space left once those in-flight words have landed.
module refill_credit
  import bs_refill_pkg::*;
#(
  parameter int addr_bits = 10
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 hs,
  input  logic [LEN_BITS-1:0]  len,
  input  logic                 fifo_wr,
  input  logic [addr_bits-1:0] words_avail,
  output logic [addr_bits:0]   inflight,
  output logic [addr_bits:0]   space
);

  localparam logic [addr_bits:0] CAP = (addr_bits + 1)'((1 << addr_bits) - 1);

  logic [addr_bits:0] inflight_next;

  // A word stays counted until it is actually written, so the registered
  // write stage never lets the FIFO be over-committed.
  always_comb begin
    inflight_next = inflight;
    if (hs) begin
      inflight_next = inflight_next + (addr_bits + 1)'(len);
    end
    if (fifo_wr) begin
      inflight_next = inflight_next - (addr_bits + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_next;
    end
  end

  assign space = CAP - {1'b0, words_avail} - inflight;

endmodule

// File: rtl/bs_refill_ctrl.sv
// Walks a byte range in external memory, issuing burst reads only when the
// FIFO can absorb the burst plus everything already in flight.
module bs_refill_ctrl
  import bs_refill_pkg::*;
#(
  parameter int addr_bits     = 10,
  parameter int burst_len     = 16,
  parameter int mem_addr_bits = 32
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     start,
  input  logic [mem_addr_bits-1:0] base_addr,
  input  logic [mem_addr_bits-1:0] end_addr,
  input  logic [addr_bits-1:0]     words_avail,
  input  logic                     wr_full,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [mem_addr_bits-1:0] req_addr,
  output logic [7:0]               req_len,
  input  logic                     rsp_valid,
  input  logic [63:0]              rsp_data,
  output logic                     fifo_wr,
  output logic [63:0]              fifo_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CMP_W = (addr_bits + 1 > LEN_BITS) ? addr_bits + 1 : LEN_BITS;
  localparam logic [mem_addr_bits-1:0] WORD_MASK = mem_addr_bits'(WORD_BYTES - 1);

  state_t                   state_reg;
  logic [mem_addr_bits-1:0] cur_addr_reg;
  logic [mem_addr_bits-1:0] rem_words_reg;
  logic [mem_addr_bits-1:0] base_al;
  logic [mem_addr_bits-1:0] start_words;
  logic [LEN_BITS-1:0]      len;
  logic [addr_bits:0]       inflight;
  logic [addr_bits:0]       space;
  logic                     hs;
  logic                     fits;

  assign base_al     = base_addr & ~WORD_MASK;
  assign start_words = (end_addr - base_al + WORD_MASK) >> 3;
  assign len         = (rem_words_reg >= mem_addr_bits'(burst_len)) ? LEN_BITS'(burst_len)
                                                                    : rem_words_reg[LEN_BITS-1:0];
  assign fits        = CMP_W'(space) >= CMP_W'(len);
  assign hs          = (state_reg == ST_REQ) && req_valid && req_ready;

  refill_credit #(
    .addr_bits(addr_bits)
  ) u_credit (
    .clk        (clk),
    .aclr       (aclr),
    .hs         (hs),
    .len        (req_len),
    .fifo_wr    (fifo_wr),
    .words_avail(words_avail),
    .inflight   (inflight),
    .space      (space)
  );

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_reg     <= ST_IDLE;
      cur_addr_reg  <= '0;
      rem_words_reg <= '0;
      req_valid     <= 1'b0;
      req_addr      <= '0;
      req_len       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cur_addr_reg  <= base_al;
            rem_words_reg <= start_words;
            busy          <= 1'b1;
            state_reg     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (rem_words_reg == '0) begin
            state_reg <= ST_DRAIN;
          end else if (fits) begin
            req_valid <= 1'b1;
            req_addr  <= cur_addr_reg;
            req_len   <= len;
            state_reg <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Address and length stay frozen until the reader takes them.
          if (req_ready) begin
            req_valid     <= 1'b0;
            cur_addr_reg  <= cur_addr_reg + (mem_addr_bits'(req_len) << 3);
            rem_words_reg <= rem_words_reg - mem_addr_bits'(req_len);
            state_reg     <= ST_CALC;
          end
        end
        ST_DRAIN: begin
          if (inflight == '0) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_FIN;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // A response with nothing outstanding is dropped; writing into a full
  // FIFO is flagged but the word is still passed on.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      fifo_wr      <= 1'b0;
      fifo_wr_data <= '0;
      err          <= 1'b0;
    end else begin
      fifo_wr <= rsp_valid && (inflight != '0);
      if (rsp_valid) begin
        fifo_wr_data <= rsp_data;
      end
      if (rsp_valid && ((inflight == '0) || wr_full)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bs_refill_ctrl.sv
// Directed bench for bs_refill_ctrl with a 64-deep FIFO model and a
// one-cycle-latency memory reader model.
module tb_bs_refill_ctrl;

  localparam int AB = 6;

  logic        clk = 1'b0;
  logic        aclr;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] end_addr;
  logic [AB-1:0] words_avail;
  logic        wr_full;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        fifo_wr;
  logic [63:0] fifo_wr_data;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  bs_refill_ctrl #(
    .addr_bits(AB),
    .burst_len(16),
    .mem_addr_bits(32)
  ) dut (
    .clk         (clk),
    .aclr        (aclr),
    .start       (start),
    .base_addr   (base_addr),
    .end_addr    (end_addr),
    .words_avail (words_avail),
    .wr_full     (wr_full),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .fifo_wr     (fifo_wr),
    .fifo_wr_data(fifo_wr_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {~a, a};
  endfunction

  logic [31:0] rsp_q[$];
  logic [39:0] req_log[$];
  int          fifo_cnt  = 0;
  int          wr_last   = 0;
  int          pop_req   = 0;
  int          wr_cnt    = 0;
  int          done_cnt  = 0;
  bit          pop_auto  = 1'b1;
  bit          inject    = 1'b0;
  bit          full_seen = 1'b0;
  logic [31:0] exp_addr  = '0;

  // Environment: FIFO occupancy, reader responses, write/request logging.
  initial begin : env
    logic [31:0] a;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    words_avail = '0;
    wr_full     = 1'b0;
    forever begin
      @(negedge clk);
      if (aclr) begin
        rsp_q.delete();
        fifo_cnt  = 0;
        wr_last   = 0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end else begin
        fifo_cnt += wr_last;
        if ((pop_auto || pop_req > 0) && fifo_cnt > 0) begin
          fifo_cnt--;
          if (pop_req > 0) pop_req--;
        end
        wr_last = fifo_wr ? 1 : 0;
        if (fifo_cnt >= 64) full_seen = 1'b1;
        if (fifo_wr) begin
          check("wr_data", fifo_wr_data, pat(exp_addr));
          exp_addr += 32'd8;
          wr_cnt++;
        end
        if (done) done_cnt++;
        if (inject) begin
          rsp_valid = 1'b1;
          rsp_data  = 64'hDEAD_BEEF;
          inject    = 1'b0;
        end else if (rsp_q.size() > 0) begin
          a         = rsp_q.pop_front();
          rsp_valid = 1'b1;
          rsp_data  = pat(a);
        end else begin
          rsp_valid = 1'b0;
        end
        if (req_valid && req_ready) begin
          req_log.push_back({req_len, req_addr});
          $display("req addr=%08h len=%0d", req_addr, req_len);
          for (int i = 0; i < int'(req_len); i++) rsp_q.push_back(req_addr + 32'(i * 8));
        end
      end
      words_avail = AB'(fifo_cnt);
      wr_full     = (fifo_cnt >= 64);
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] e);
    req_log.delete();
    wr_cnt    = 0;
    done_cnt  = 0;
    exp_addr  = b & ~32'h7;
    base_addr = b;
    end_addr  = e;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_fin"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_ndone"}, done_cnt, 1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] b, input int words);
    int          rem = words;
    int          n   = (words + 15) / 16;
    int          l;
    logic [31:0] a   = b;
    check({tag, "_nreq"}, req_log.size(), n);
    for (int i = 0; i < req_log.size() && i < n; i++) begin
      l = (rem > 16) ? 16 : rem;
      check($sformatf("%s_addr%0d", tag, i), req_log[i][31:0], a);
      check($sformatf("%s_len%0d", tag, i), req_log[i][39:32], l);
      a   += 32'd128;
      rem -= l;
    end
    check({tag, "_words"}, wr_cnt, words);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin : main
    aclr      = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    end_addr  = '0;
    req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_len", req_len, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    aclr = 1'b0;
    @(posedge clk); #1;

    // 128 words, eight full bursts
    do_start(32'h1000, 32'h1400);
    check("basic_busy_c1", busy, 1);
    check("basic_noreq_c1", req_valid, 0);
    @(posedge clk); #1;
    check("basic_req_c2", req_valid, 1);
    check("basic_addr_c2", req_addr, 32'h1000);
    check("basic_len_c2", req_len, 16);
    wait_done("basic");
    check_stream("basic", 32'h1000, 128);

    // 0xA3 bytes rounds up to 21 words: 16 then 5
    do_start(32'h2000, 32'h20A3);
    wait_done("tail");
    check_stream("tail", 32'h2000, 21);

    // FIFO never popped: credit allows only 48 words
    repeat (80) @(posedge clk);
    #1;
    pop_auto  = 1'b0;
    full_seen = 1'b0;
    do_start(32'h3000, 32'h3280);
    repeat (70) @(posedge clk);
    #1;
    check("stall_nreq", req_log.size(), 3);
    check("stall_avail", words_avail, 48);
    check("stall_noreq", req_valid, 0);
    check("stall_busy", busy, 1);
    pop_req = 1;
    repeat (10) @(posedge clk);
    #1;
    check("stall_nreq_pop", req_log.size(), 4);
    pop_auto = 1'b1;
    wait_done("stall");
    check_stream("stall", 32'h3000, 80);
    check("stall_nofull", full_seen, 0);

    // reader stalls the first request
    req_ready = 1'b0;
    do_start(32'h4000, 32'h4100);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", req_valid, 1);
      check("bp_addr", req_addr, 32'h4000);
      check("bp_len", req_len, 16);
      @(posedge clk); #1;
    end
    check("bp_nolog", req_log.size(), 0);
    req_ready = 1'b1;
    wait_done("bp");
    check_stream("bp", 32'h4000, 32);

    // stray response while idle
    repeat (5) @(posedge clk);
    #1;
    wr_cnt = 0;
    inject = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stray_err", err, 1);
    check("stray_nowr", wr_cnt, 0);

    // reset in the middle of a stream, then restart
    do_start(32'h6000, 32'h6400);
    repeat (6) @(posedge clk);
    #1;
    aclr = 1'b1;
    #1;
    check("abort_req_valid", req_valid, 0);
    check("abort_req_addr", req_addr, 0);
    check("abort_req_len", req_len, 0);
    check("abort_fifo_wr", fifo_wr, 0);
    check("abort_wr_data", fifo_wr_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    @(posedge clk); #1;
    aclr = 1'b0;
    @(posedge clk); #1;
    do_start(32'h7000, 32'h7200);
    wait_done("restart");
    check_stream("restart", 32'h7000, 64);

    // address space wrap
    do_start(32'hFFFF_FFC0, 32'h0000_0040);
    wait_done("wrap");
    check_stream("wrap", 32'hFFFF_FFC0, 16);
    do_start(32'hFFFF_FFC0, 32'h0000_00C0);
    wait_done("wrap2");
    check_stream("wrap2", 32'hFFFF_FFC0, 32);

    // empty stream: done three cycles after start
    do_start(32'h5000, 32'h5000);
    check("degen_c1", done, 0);
    @(posedge clk); #1;
    check("degen_c2", done, 0);
    @(posedge clk); #1;
    check("degen_c3", done, 1);
    @(posedge clk); #1;
    check("degen_c4", done, 0);
    check("degen_nreq", req_log.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
